// File: rtl/commit_ctrl_pkg.sv
// Shared widths, instruction-id encodings and class predicates for the commit stage.
package commit_ctrl_pkg;
  localparam int InstrIdWidth = 6;
  localparam int RegIdxWidth  = 5;
  localparam int ROBIdxWidth  = 4;
  localparam int WordWidth    = 32;
  localparam int AddrWidth    = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic [WordWidth-1:0] ZERO = '0;

  localparam logic [InstrIdWidth-1:0] ID_NONE = 6'd0,  ID_LUI  = 6'd1,  ID_AUIPC = 6'd2;
  localparam logic [InstrIdWidth-1:0] ID_JAL  = 6'd3,  ID_JALR = 6'd4;
  localparam logic [InstrIdWidth-1:0] ID_BEQ  = 6'd5,  ID_BNE  = 6'd6,  ID_BLT   = 6'd7;
  localparam logic [InstrIdWidth-1:0] ID_BGE  = 6'd8,  ID_BLTU = 6'd9,  ID_BGEU  = 6'd10;
  localparam logic [InstrIdWidth-1:0] ID_LB   = 6'd11, ID_LH   = 6'd12, ID_LW    = 6'd13;
  localparam logic [InstrIdWidth-1:0] ID_LBU  = 6'd14, ID_LHU  = 6'd15;
  localparam logic [InstrIdWidth-1:0] ID_SB   = 6'd16, ID_SH   = 6'd17, ID_SW    = 6'd18;
  localparam logic [InstrIdWidth-1:0] ID_ADDI = 6'd19, ID_ADD  = 6'd28;

  typedef enum logic {ST_IDLE, ST_FLUSH} state_e;

  function automatic logic is_branch(input logic [InstrIdWidth-1:0] id);
    return (id >= ID_BEQ) && (id <= ID_BGEU);
  endfunction

  function automatic logic is_jal(input logic [InstrIdWidth-1:0] id);
    return id == ID_JAL;
  endfunction

  function automatic logic is_jalr(input logic [InstrIdWidth-1:0] id);
    return id == ID_JALR;
  endfunction

  function automatic logic is_store(input logic [InstrIdWidth-1:0] id);
    return (id >= ID_SB) && (id <= ID_SW);
  endfunction

  function automatic logic writes_rd(input logic [InstrIdWidth-1:0] id);
    return (id != ID_NONE) && !is_branch(id) && !is_store(id);
  endfunction
endpackage

// File: rtl/commit_ctrl_if.sv
// ROB commit port plus the regfile / predictor / fetch / counter outputs of the commit stage.
interface commit_ctrl_if
  import commit_ctrl_pkg::*;
#(parameter int CNT_WIDTH = 32);
  logic                    commit_en_in;
  logic [InstrIdWidth-1:0] instr_id_in;
  logic [RegIdxWidth-1:0]  rd_in;
  logic [ROBIdxWidth-1:0]  rob_pos_in;
  logic [WordWidth-1:0]    res_in;
  logic                    jump_en_in;
  logic [AddrWidth-1:0]    jump_a_in;
  logic [AddrWidth-1:0]    pc_in;
  logic                    bp_in;

  logic                    reg_we_out;
  logic [RegIdxWidth-1:0]  reg_rd_out;
  logic [WordWidth-1:0]    reg_data_out;
  logic [ROBIdxWidth-1:0]  reg_rob_pos_out;
  logic                    bp_upd_en_out;
  logic [AddrWidth-1:0]    bp_upd_pc_out;
  logic                    bp_upd_taken_out;
  logic                    clear_branch_out;
  logic                    redirect_en_out;
  logic [AddrWidth-1:0]    redirect_pc_out;
  logic [CNT_WIDTH-1:0]    retire_cnt_out;
  logic [CNT_WIDTH-1:0]    mispred_cnt_out;

  modport master (
    input  commit_en_in, instr_id_in, rd_in, rob_pos_in, res_in,
           jump_en_in, jump_a_in, pc_in, bp_in,
    output reg_we_out, reg_rd_out, reg_data_out, reg_rob_pos_out,
           bp_upd_en_out, bp_upd_pc_out, bp_upd_taken_out,
           clear_branch_out, redirect_en_out, redirect_pc_out,
           retire_cnt_out, mispred_cnt_out
  );

  modport slave (
    output commit_en_in, instr_id_in, rd_in, rob_pos_in, res_in,
           jump_en_in, jump_a_in, pc_in, bp_in,
    input  reg_we_out, reg_rd_out, reg_data_out, reg_rob_pos_out,
           bp_upd_en_out, bp_upd_pc_out, bp_upd_taken_out,
           clear_branch_out, redirect_en_out, redirect_pc_out,
           retire_cnt_out, mispred_cnt_out
  );
endinterface

// File: rtl/commit_ctrl.sv
// Retires ROB commits into regfile/predictor updates; on a misprediction holds clear_branch
// for FLUSH_CYCLES cycles and redirects fetch once. All outputs registered, 1-cycle latency.
module commit_ctrl
  import commit_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_WIDTH    = 32
) (
  input logic           clk_in,
  input logic           rst_n_in,
  input logic           rdy_in,
  commit_ctrl_if.master cif
);
  localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);

  state_e                  r_state,         w_state_nxt;
  logic [3:0]              r_flush_cnt,     w_flush_cnt_nxt;
  logic                    r_reg_we,        w_reg_we_nxt;
  logic [RegIdxWidth-1:0]  r_reg_rd,        w_reg_rd_nxt;
  logic [WordWidth-1:0]    r_reg_data,      w_reg_data_nxt;
  logic [ROBIdxWidth-1:0]  r_reg_rob_pos,   w_reg_rob_pos_nxt;
  logic                    r_bp_upd_en,     w_bp_upd_en_nxt;
  logic [AddrWidth-1:0]    r_bp_upd_pc,     w_bp_upd_pc_nxt;
  logic                    r_bp_upd_taken,  w_bp_upd_taken_nxt;
  logic                    r_clear,         w_clear_nxt;
  logic                    r_redir_en,      w_redir_en_nxt;
  logic [AddrWidth-1:0]    r_redir_pc,      w_redir_pc_nxt;
  logic [CNT_WIDTH-1:0]    r_retire_cnt,    w_retire_cnt_nxt;
  logic [CNT_WIDTH-1:0]    r_mispred_cnt,   w_mispred_cnt_nxt;

  logic w_is_ctrl, w_mispred, w_reg_write;

  assign w_is_ctrl   = is_branch(cif.instr_id_in) || is_jal(cif.instr_id_in) || is_jalr(cif.instr_id_in);
  assign w_mispred   = w_is_ctrl && (cif.jump_en_in != cif.bp_in);
  assign w_reg_write = writes_rd(cif.instr_id_in) && (cif.rd_in != '0);

  always_comb begin
    w_state_nxt        = r_state;
    w_flush_cnt_nxt    = r_flush_cnt;
    w_reg_we_nxt       = FALSE;
    w_reg_rd_nxt       = r_reg_rd;
    w_reg_data_nxt     = r_reg_data;
    w_reg_rob_pos_nxt  = r_reg_rob_pos;
    w_bp_upd_en_nxt    = FALSE;
    w_bp_upd_pc_nxt    = r_bp_upd_pc;
    w_bp_upd_taken_nxt = r_bp_upd_taken;
    w_clear_nxt        = FALSE;
    w_redir_en_nxt     = FALSE;
    w_redir_pc_nxt     = r_redir_pc;
    w_retire_cnt_nxt   = r_retire_cnt;
    w_mispred_cnt_nxt  = r_mispred_cnt;
    case (r_state)
      ST_IDLE: begin
        if (cif.commit_en_in) begin
          w_retire_cnt_nxt = r_retire_cnt + 1'b1;
          if (w_reg_write) begin
            w_reg_we_nxt      = TRUE;
            w_reg_rd_nxt      = cif.rd_in;
            w_reg_data_nxt    = cif.res_in;
            w_reg_rob_pos_nxt = cif.rob_pos_in;
          end
          if (is_branch(cif.instr_id_in)) begin
            w_bp_upd_en_nxt    = TRUE;
            w_bp_upd_pc_nxt    = cif.pc_in;
            w_bp_upd_taken_nxt = cif.jump_en_in;
          end
          if (w_mispred) begin
            w_mispred_cnt_nxt = r_mispred_cnt + 1'b1;
            w_clear_nxt       = TRUE;
            w_redir_en_nxt    = TRUE;
            w_redir_pc_nxt    = cif.jump_en_in ? cif.jump_a_in : cif.pc_in + AddrWidth'(4);
            w_flush_cnt_nxt   = FlushLoad;
            w_state_nxt       = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        // Younger commits presented while flushing belong to the squashed path.
        if (r_flush_cnt == 4'd0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - 4'd1;
          w_clear_nxt     = TRUE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state        <= ST_IDLE;
      r_flush_cnt    <= '0;
      r_reg_we       <= FALSE;
      r_reg_rd       <= '0;
      r_reg_data     <= '0;
      r_reg_rob_pos  <= '0;
      r_bp_upd_en    <= FALSE;
      r_bp_upd_pc    <= '0;
      r_bp_upd_taken <= FALSE;
      r_clear        <= FALSE;
      r_redir_en     <= FALSE;
      r_redir_pc     <= '0;
      r_retire_cnt   <= '0;
      r_mispred_cnt  <= '0;
    end else if (rdy_in) begin
      r_state        <= w_state_nxt;
      r_flush_cnt    <= w_flush_cnt_nxt;
      r_reg_we       <= w_reg_we_nxt;
      r_reg_rd       <= w_reg_rd_nxt;
      r_reg_data     <= w_reg_data_nxt;
      r_reg_rob_pos  <= w_reg_rob_pos_nxt;
      r_bp_upd_en    <= w_bp_upd_en_nxt;
      r_bp_upd_pc    <= w_bp_upd_pc_nxt;
      r_bp_upd_taken <= w_bp_upd_taken_nxt;
      r_clear        <= w_clear_nxt;
      r_redir_en     <= w_redir_en_nxt;
      r_redir_pc     <= w_redir_pc_nxt;
      r_retire_cnt   <= w_retire_cnt_nxt;
      r_mispred_cnt  <= w_mispred_cnt_nxt;
    end
  end

  assign cif.reg_we_out       = r_reg_we;
  assign cif.reg_rd_out       = r_reg_rd;
  assign cif.reg_data_out     = r_reg_data;
  assign cif.reg_rob_pos_out  = r_reg_rob_pos;
  assign cif.bp_upd_en_out    = r_bp_upd_en;
  assign cif.bp_upd_pc_out    = r_bp_upd_pc;
  assign cif.bp_upd_taken_out = r_bp_upd_taken;
  assign cif.clear_branch_out = r_clear;
  assign cif.redirect_en_out  = r_redir_en;
  assign cif.redirect_pc_out  = r_redir_pc;
  assign cif.retire_cnt_out   = r_retire_cnt;
  assign cif.mispred_cnt_out  = r_mispred_cnt;
endmodule

// File: tb/tb_commit_ctrl.sv
// Table-driven commit vectors through a scoreboard queue, plus hand sequences for flush, freeze and reset.
module tb_commit_ctrl;
  import commit_ctrl_pkg::*;

  localparam int FC = 3;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b0;
  always #5 clk = ~clk;

  commit_ctrl_if #(.CNT_WIDTH(CW)) cif ();
  commit_ctrl #(.FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .cif(cif)
  );

  typedef struct {
    logic [InstrIdWidth-1:0] id;
    logic [RegIdxWidth-1:0]  rd;
    logic [ROBIdxWidth-1:0]  pos;
    logic [31:0]             res;
    logic                    je;
    logic [31:0]             ja;
    logic [31:0]             pc;
    logic                    bp;
    logic                    e_we;
    logic                    e_bpu;
    logic                    e_bpt;
    logic                    e_mis;
    logic [31:0]             e_rpc;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[8];
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_ret = 0;
  logic [31:0] exp_mis = 0;

  function automatic vec_t mk(input logic [5:0] id, input logic [4:0] rd, input logic [3:0] pos,
                              input logic [31:0] res, input logic je, input logic [31:0] ja,
                              input logic [31:0] pc, input logic bp, input logic e_we,
                              input logic e_bpu, input logic e_bpt, input logic e_mis,
                              input logic [31:0] e_rpc);
    vec_t v;
    v.id = id; v.rd = rd; v.pos = pos; v.res = res; v.je = je; v.ja = ja; v.pc = pc; v.bp = bp;
    v.e_we = e_we; v.e_bpu = e_bpu; v.e_bpt = e_bpt; v.e_mis = e_mis; v.e_rpc = e_rpc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    cif.commit_en_in = 1'b1;
    cif.instr_id_in  = v.id;
    cif.rd_in        = v.rd;
    cif.rob_pos_in   = v.pos;
    cif.res_in       = v.res;
    cif.jump_en_in   = v.je;
    cif.jump_a_in    = v.ja;
    cif.pc_in        = v.pc;
    cif.bp_in        = v.bp;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " reg_we"}, 32'(cif.reg_we_out), 0);
    chk({tag, " reg_data"}, cif.reg_data_out, 0);
    chk({tag, " reg_rd"}, 32'(cif.reg_rd_out), 0);
    chk({tag, " bp_upd_en"}, 32'(cif.bp_upd_en_out), 0);
    chk({tag, " clear"}, 32'(cif.clear_branch_out), 0);
    chk({tag, " redirect_en"}, 32'(cif.redirect_en_out), 0);
    chk({tag, " redirect_pc"}, cif.redirect_pc_out, 0);
    chk({tag, " retire_cnt"}, cif.retire_cnt_out, 0);
    chk({tag, " mispred_cnt"}, cif.mispred_cnt_out, 0);
  endtask

  // Drive one commit at a negedge, let it be accepted, then compare the popped expectation.
  task automatic apply(input vec_t v);
    vec_t e;
    drive(v);
    sb.push_back(v);
    @(posedge clk);
    exp_ret++;
    if (v.e_mis) exp_mis++;
    @(negedge clk);
    cif.commit_en_in = 1'b0;
    e = sb.pop_front();
    chk("reg_we", 32'(cif.reg_we_out), 32'(e.e_we));
    if (e.e_we) begin
      chk("reg_rd", 32'(cif.reg_rd_out), 32'(e.rd));
      chk("reg_data", cif.reg_data_out, e.res);
      chk("reg_rob_pos", 32'(cif.reg_rob_pos_out), 32'(e.pos));
    end
    chk("bp_upd_en", 32'(cif.bp_upd_en_out), 32'(e.e_bpu));
    if (e.e_bpu) begin
      chk("bp_upd_pc", cif.bp_upd_pc_out, e.pc);
      chk("bp_upd_taken", 32'(cif.bp_upd_taken_out), 32'(e.e_bpt));
    end
    chk("clear_branch", 32'(cif.clear_branch_out), 32'(e.e_mis));
    chk("redirect_en", 32'(cif.redirect_en_out), 32'(e.e_mis));
    if (e.e_mis) chk("redirect_pc", cif.redirect_pc_out, e.e_rpc);
    chk("retire_cnt", cif.retire_cnt_out, exp_ret);
    chk("mispred_cnt", cif.mispred_cnt_out, exp_mis);
  endtask

  // Remaining flush cycles after the detection cycle; optionally a younger commit is offered.
  task automatic flush_tail(input logic with_commit);
    if (with_commit) drive(mk(ID_ADDI, 5'd9, 4'd6, 32'hbad, 1'b0, 0, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    for (int k = 1; k < FC; k++) begin
      @(negedge clk);
      cif.commit_en_in = 1'b0;
      chk("flush clear", 32'(cif.clear_branch_out), 1);
      chk("flush redirect_en", 32'(cif.redirect_en_out), 0);
      chk("flush reg_we", 32'(cif.reg_we_out), 0);
      chk("flush bp_upd_en", 32'(cif.bp_upd_en_out), 0);
      chk("flush retire_cnt", cif.retire_cnt_out, exp_ret);
    end
    @(negedge clk);
    chk("flush end clear", 32'(cif.clear_branch_out), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = mk(ID_ADDI, 5'd5, 4'd3, 32'h1234, 1'b0, 0, 32'h10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    tbl[1] = mk(ID_ADDI, 5'd0, 4'd4, 32'h55, 1'b0, 0, 32'h14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    tbl[2] = mk(ID_BEQ, 5'd0, 4'd5, 0, 1'b1, 32'h200, 32'h100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    tbl[3] = mk(ID_SW, 5'd7, 4'd6, 32'h99, 1'b0, 0, 32'h120, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    tbl[4] = mk(ID_BNE, 5'd0, 4'd7, 0, 1'b0, 32'h400, 32'h300, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    tbl[5] = mk(ID_JAL, 5'd1, 4'd8, 32'h44, 1'b1, 32'h80, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    tbl[6] = mk(ID_LW, 5'd31, 4'd15, 32'hdeadbeef, 1'b0, 0, 32'h60, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    tbl[7] = mk(ID_LUI, 5'd2, 4'd9, 32'h12345000, 1'b0, 0, 32'h64, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    cif.commit_en_in = 1'b0; cif.instr_id_in = '0; cif.rd_in = '0; cif.rob_pos_in = '0;
    cif.res_in = '0; cif.jump_en_in = 1'b0; cif.jump_a_in = '0; cif.pc_in = '0; cif.bp_in = 1'b0;
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rdy = 1'b1;
    @(negedge clk);
    check_zero("post-reset idle");

    for (int i = 0; i < 8; i++) apply(tbl[i]);

    // Taken branch predicted not-taken, with a younger commit offered during the flush.
    apply(mk(ID_BEQ, 5'd0, 4'd1, 0, 1'b1, 32'h200, 32'h100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h200));
    flush_tail(1'b1);

    // Not-taken branch predicted taken: fall-through redirect; rd on a branch is never written.
    apply(mk(ID_BNE, 5'd3, 4'd2, 0, 1'b0, 32'h900, 32'h200, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h204));
    flush_tail(1'b0);

    // JALR mispredict: link write and redirect in the same cycle, no predictor update.
    apply(mk(ID_JALR, 5'd1, 4'd2, 32'h108, 1'b1, 32'h500, 32'h104, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h500));
    flush_tail(1'b0);

    // Freeze for 3 cycles right after detection: everything holds, flush stretches by 3.
    apply(mk(ID_BGE, 5'd0, 4'd3, 0, 1'b1, 32'h700, 32'h600, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h700));
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("frozen clear", 32'(cif.clear_branch_out), 1);
      chk("frozen redirect_en", 32'(cif.redirect_en_out), 1);
      chk("frozen redirect_pc", cif.redirect_pc_out, 32'h700);
      chk("frozen mispred_cnt", cif.mispred_cnt_out, exp_mis);
    end
    rdy = 1'b1;
    flush_tail(1'b0);

    // Reset in the middle of a flush clears everything without waiting for a clock edge.
    apply(mk(ID_BLT, 5'd0, 4'd4, 0, 1'b0, 32'h800, 32'h7f0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h7f4));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("mid-flush reset");
    exp_ret = 0;
    exp_mis = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply(tbl[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/commit_ctrl.md
Name: commit_ctrl

Overview:
Sequences instruction retirement from the reorder buffer's commit port.
- For each committed entry: drives the register-file write/rename-release, the branch-predictor update and the retire counters.
- Detects branch/jump mispredictions and runs a flush FSM that pulses clear_branch to ROB/RS/LSB/issue and redirects fetch.
- Sits between the ROB commit outputs and regfile, predictor and IF.

Parameters:
FLUSH_CYCLES, 1, cycles clear_branch_out stays high per misprediction (1..15).
CNT_WIDTH, 32, width of the retire and mispredict performance counters.

Ports:
clk_in  in  1  clock, rising edge
rst_n_in  in  1  asynchronous active-low reset
rdy_in  in  1  global ready; low freezes all state and outputs
commit_en_in  in  1  ROB presents a committing entry this cycle
instr_id_in  in  `InstrIdWidth  decoded instruction id of the entry
rd_in  in  `RegIdxWidth  destination register
rob_pos_in  in  `ROBIdxWidth  ROB slot of the entry
res_in  in  `WordWidth  result value
jump_en_in  in  1  resolved taken
jump_a_in  in  `AddrWidth  resolved target
pc_in  in  `AddrWidth  instruction PC
bp_in  in  1  predicted taken at fetch
reg_we_out  out  1  regfile write pulse
reg_rd_out  out  `RegIdxWidth  write index
reg_data_out  out  `WordWidth  write data
reg_rob_pos_out  out  `ROBIdxWidth  tag; regfile clears rename only if tag matches
bp_upd_en_out  out  1  predictor update pulse
bp_upd_pc_out  out  `AddrWidth  PC to train
bp_upd_taken_out  out  1  resolved direction
clear_branch_out  out  1  global flush
redirect_en_out  out  1  fetch redirect pulse, first flush cycle only
redirect_pc_out  out  `AddrWidth  new fetch PC
retire_cnt_out  out  CNT_WIDTH  committed-instruction count
mispred_cnt_out  out  CNT_WIDTH  misprediction count

Behaviour:
- Reset (async, rst_n_in=0): every output is 0, state=IDLE, flush counter 0. Release is sampled on the next clock edge.
- rdy_in=0: no register changes; outputs hold their values.
- All outputs are registered. Latency is 1 cycle: an accepted commit at edge T produces its outputs during T+1.
- Pulse outputs (reg_we, bp_upd_en, redirect_en) are high for exactly 1 cycle per event unless frozen by rdy_in.
- FSM states: IDLE, FLUSH.
- IDLE, commit_en_in=1, the commit is accepted:
  - retire_cnt +1, wrapping at 2^CNT_WIDTH.
  - reg_we=1 iff the instruction class writes rd (not branch/store) and rd_in!=0. Then reg_rd=rd_in, reg_data=res_in, reg_rob_pos=rob_pos_in.
  - Class is control (branch/JAL/JALR): bp_upd_en=1 for conditional branches only, with pc_in and jump_en_in.
  - Mispredict condition: control class and jump_en_in!=bp_in.
  - On mispredict: mispred_cnt +1; clear_branch=1; redirect_en=1; redirect_pc = jump_a_in if jump_en_in else pc_in+4 (AddrWidth wrap). Load the flush counter with FLUSH_CYCLES-1 and go to FLUSH. If FLUSH_CYCLES=1, return to IDLE on the next edge with clear_branch dropping.
  - The register write of the mispredicting jump itself (JAL/JALR link) still occurs.
- FLUSH:
  - commit_en_in is ignored: no writes, no counting. This covers the younger entry the ROB may present in the cycle after detection.
  - clear_branch stays 1 and redirect_en is 0.
  - The counter decrements each cycle. At 0, the next edge goes to IDLE and drops clear_branch.
- Commit in IDLE with no mispredict: clear_branch=0, redirect_en=0.
- Reset mid-flush aborts immediately to IDLE, outputs 0.

Decomposition:
- Shared config header: instruction-id encodings and class predicates (is_branch, is_jal, is_jalr, is_store, writes_rd), TRUE/FALSE/ZERO, and the width macros already used by the ROB.
- No sub-module is needed. The flush FSM and counters live in a single always block plus combinational class decode.

Test Plan:
- Reset, then ADDI rd=5 res=0x1234 pos=3 committed -> next cycle reg_we=1, rd=5, data=0x1234, tag=3; retire_cnt=1; clear_branch=0.
- Commit with rd=0 -> reg_we=0; retire_cnt still increments.
- BEQ pc=0x100, bp=0, jump_en=1, a=0x200 -> bp_upd(0x100,1); redirect_en=1, pc=0x200; clear_branch high for FLUSH_CYCLES cycles; mispred_cnt=1.
- Same flow with bp=1, jump_en=0 -> redirect_pc=0x104. A commit_en pulse during FLUSH -> no reg_we, retire_cnt unchanged.
- JALR rd=1 res=0x108 jump_en=1 bp=0 -> reg_we=1 and redirect in the same cycle; bp_upd_en=0.
- rdy_in low for 3 cycles during FLUSH -> clear_branch held, flush length extended by 3. Assert rst_n_in mid-flush -> all outputs 0 immediately.
